dac_spi_tx: RTL and testbench

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dac_spi_tx.sv | 116 +++++++++++
 tb/tb_dac_spi_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// Serialises 8-bit waveform samples into 16-bit DAC frames {ctrl, sample, 0000}
// over a mode-0 SPI link: chip select framing, MSB first, data launched on sclk fall.
module dac_spi_tx #(
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] CTRL_BITS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_mosi,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] state_dbg
);

  // Handshake: a sample transfers on a rising clk edge where din_valid && din_ready.
  // din_ready depends only on state, never on din_valid.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    HOLD   = 3'd3,
    CSHIGH = 3'd4
  } state_t;

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [4:0]  phase, phase_nx;
  logic [15:0] shreg, shreg_nx;
  logic        tick;
  logic        accept;

  logic        cs_n_nx;
  logic        sclk_nx;
  logic        mosi_nx;
  logic        busy_nx;
  logic        done_nx;

  assign din_ready = (state == IDLE);
  assign accept    = din_valid && din_ready;
  assign tick      = (cnt == 8'd0);
  assign state_dbg = state;

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= RELOAD;
      phase      <= 5'd0;
      shreg      <= 16'd0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      phase      <= phase_nx;
      shreg      <= shreg_nx;
      dac_cs_n   <= cs_n_nx;
      dac_sclk   <= sclk_nx;
      dac_mosi   <= mosi_nx;
      busy       <= busy_nx;
      frame_done <= done_nx;
    end
  end

  // Next state plus counter/phase/shift-register updates. Each SHIFT phase is one
  // sclk half-period; even phases are high, and the shift happens when an even
  // phase ends, i.e. on the falling sclk edge.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)                   state_nx = SETUP;
      SETUP:   if (tick)                     state_nx = SHIFT;
      SHIFT:   if (tick && phase == 5'd31)   state_nx = HOLD;
      HOLD:    if (tick)                     state_nx = CSHIGH;
      CSHIGH:  if (tick)                     state_nx = IDLE;
      default:                               state_nx = IDLE;
    endcase

    if (state == IDLE || state_nx != state || tick) cnt_nx = RELOAD;
    else                                            cnt_nx = cnt - 8'd1;

    phase_nx = phase;
    if (state_nx == SHIFT && state != SHIFT) phase_nx = 5'd0;
    else if (state == SHIFT && tick)         phase_nx = phase + 5'd1;

    shreg_nx = shreg;
    if (accept)                                shreg_nx = {CTRL_BITS, din, 4'b0000};
    else if (state == SHIFT && tick && !phase[0]) shreg_nx = {shreg[14:0], 1'b0};
  end

  // Output decode from the upcoming state so the pins line up with state.
  always_comb begin
    cs_n_nx = 1'b1;
    sclk_nx = 1'b0;
    mosi_nx = 1'b0;
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == CSHIGH) && (state != CSHIGH);
    if (state_nx == SETUP || state_nx == SHIFT || state_nx == HOLD) begin
      cs_n_nx = 1'b0;
      mosi_nx = shreg_nx[15];
    end
    if (state_nx == SHIFT) sclk_nx = !phase_nx[0];
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: one default-parameter instance (a) and one
// CLK_DIV=1 / CTRL_BITS=0011 instance (b), with sclk-edge monitors capturing frames.
module tb_dac_spi_tx;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int assert_cnt = 0;
  int fail_cnt = 0;

  logic [7:0] din_a = 8'd0, din_b = 8'd0;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic ready_a, cs_a, sclk_a, mosi_a, busy_a, done_a;
  logic ready_b, cs_b, sclk_b, mosi_b, busy_b, done_b;
  logic [2:0] st_a, st_b;

  dac_spi_tx #(.CLK_DIV(4), .CTRL_BITS(4'b0000)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .dac_cs_n(cs_a), .dac_sclk(sclk_a), .dac_mosi(mosi_a), .busy(busy_a),
    .frame_done(done_a), .state_dbg(st_a)
  );

  dac_spi_tx #(.CLK_DIV(1), .CTRL_BITS(4'b0011)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .dac_cs_n(cs_b), .dac_sclk(sclk_b), .dac_mosi(mosi_b), .busy(busy_b),
    .frame_done(done_b), .state_dbg(st_b)
  );

  // scoreboard state
  logic [15:0] exp_q[$];
  logic [15:0] got_a[$], got_b[$];
  int bits_a[$], len_a[$], bits_b[$], len_b[$];

  // monitor a
  logic sclk_pa = 1'b0, mosi_pa = 1'b0, cs_pa = 1'b1;
  logic [15:0] cap_a = 16'd0;
  int nbits_a = 0, cs_low_a = 0, done_n_a = 0, done_cyc_a = 0, viol_a = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      nbits_a <= 0; cap_a <= 16'd0; cs_low_a <= 0;
    end else begin
      if (sclk_a && !sclk_pa) begin
        cap_a <= {cap_a[14:0], mosi_a};
        nbits_a <= nbits_a + 1;
        if (mosi_a !== mosi_pa) viol_a <= viol_a + 1;
      end else if (sclk_a && sclk_pa && mosi_a !== mosi_pa) viol_a <= viol_a + 1;
      if (done_a) begin done_n_a <= done_n_a + 1; done_cyc_a <= cyc; end
      if (cs_a && !cs_pa) begin
        got_a.push_back(cap_a); bits_a.push_back(nbits_a); len_a.push_back(cs_low_a);
        cap_a <= 16'd0; nbits_a <= 0; cs_low_a <= 0;
      end else if (!cs_a) cs_low_a <= cs_low_a + 1;
    end
    sclk_pa <= sclk_a; mosi_pa <= mosi_a; cs_pa <= cs_a;
  end

  // monitor b
  logic sclk_pb = 1'b0, mosi_pb = 1'b0, cs_pb = 1'b1;
  logic [15:0] cap_b = 16'd0;
  int nbits_b = 0, cs_low_b = 0, last_rise_b = 0, gap_bad_b = 0, viol_b = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      nbits_b <= 0; cap_b <= 16'd0; cs_low_b <= 0;
    end else begin
      if (sclk_b && !sclk_pb) begin
        cap_b <= {cap_b[14:0], mosi_b};
        nbits_b <= nbits_b + 1;
        if (nbits_b > 0 && cyc - last_rise_b != 2) gap_bad_b <= gap_bad_b + 1;
        last_rise_b <= cyc;
        if (mosi_b !== mosi_pb) viol_b <= viol_b + 1;
      end
      if (cs_b && !cs_pb) begin
        got_b.push_back(cap_b); bits_b.push_back(nbits_b); len_b.push_back(cs_low_b);
        cap_b <= 16'd0; nbits_b <= 0; cs_low_b <= 0;
      end else if (!cs_b) cs_low_b <= cs_low_b + 1;
    end
    sclk_pb <= sclk_b; mosi_pb <= mosi_b; cs_pb <= cs_b;
  end

  // driver tasks (called at a falling clk edge)
  task automatic send(input bit sel, input logic [7:0] d, output int acc, output bit to);
    int i;
    if (sel) begin din_b = d; valid_b = 1'b1; end
    else begin din_a = d; valid_a = 1'b1; end
    i = 0;
    while (i < 500 && (sel ? ready_b : ready_a) !== 1'b1) begin @(negedge clk); i++; end
    to = (i >= 500);
    acc = cyc;
    @(negedge clk);
    if (sel) valid_b = 1'b0; else valid_a = 1'b0;
  endtask

  task automatic wait_ready(input bit sel, output int c, output bit to);
    int i;
    i = 0;
    while (i < 500 && (sel ? ready_b : ready_a) !== 1'b1) begin @(negedge clk); i++; end
    to = (i >= 500);
    c = cyc;
  endtask

  task automatic wait_frames(input bit sel, input int n, output bit to);
    int i;
    i = 0;
    while (i < 1000 && (sel ? got_b.size() : got_a.size()) < n) begin @(negedge clk); i++; end
    to = (i >= 1000);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    assert_cnt++; if (cs_a !== 1'b1) begin fail_cnt++; $display("FAIL reset_cs_n got=%b exp=1", cs_a); end
    assert_cnt++; if (sclk_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_sclk got=%b exp=0", sclk_a); end
    assert_cnt++; if (mosi_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_mosi got=%b exp=0", mosi_a); end
    assert_cnt++; if (busy_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    assert_cnt++; if (done_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_frame_done got=%b exp=0", done_a); end
    assert_cnt++; if (st_a !== 3'd0) begin fail_cnt++; $display("FAIL reset_state got=%0d exp=0", st_a); end
    assert_cnt++; if (cs_b !== 1'b1) begin fail_cnt++; $display("FAIL reset_cs_n_b got=%b exp=1", cs_b); end
    rst_n = 1'b1;
    @(negedge clk);
    assert_cnt++; if (ready_a !== 1'b1) begin fail_cnt++; $display("FAIL post_reset_ready got=%b exp=1", ready_a); end
    assert_cnt++; if (ready_b !== 1'b1) begin fail_cnt++; $display("FAIL post_reset_ready_b got=%b exp=1", ready_b); end
  endtask

  task automatic test_default_frame;
    int acc, rc, dn0;
    bit to;
    logic [15:0] got, exp;
    dn0 = done_n_a;
    exp_q.push_back(16'h0A50);
    send(1'b0, 8'hA5, acc, to);
    assert_cnt++; if (to) begin fail_cnt++; $display("FAIL a5_accept got=timeout exp=accept"); end
    @(negedge clk);
    assert_cnt++; if (busy_a !== 1'b1) begin fail_cnt++; $display("FAIL a5_busy got=%b exp=1", busy_a); end
    wait_ready(1'b0, rc, to);
    assert_cnt++; if (to || rc - acc != 141) begin fail_cnt++; $display("FAIL a5_ready_latency got=%0d exp=141", rc - acc); end
    wait_frames(1'b0, 1, to);
    assert_cnt++; if (to) begin fail_cnt++; $display("FAIL a5_frame got=timeout exp=frame"); end
    if (!to) begin
      got = got_a.pop_front(); exp = exp_q.pop_front();
      assert_cnt++; if (got !== exp) begin fail_cnt++; $display("FAIL a5_bits got=%h exp=%h", got, exp); end
      assert_cnt++; if (bits_a[0] != 16) begin fail_cnt++; $display("FAIL a5_rising_edges got=%0d exp=16", bits_a[0]); end
      assert_cnt++; if (len_a[0] != 136) begin fail_cnt++; $display("FAIL a5_cs_low got=%0d exp=136", len_a[0]); end
      void'(bits_a.pop_front()); void'(len_a.pop_front());
    end
    assert_cnt++; if (done_n_a - dn0 != 1) begin fail_cnt++; $display("FAIL a5_done_count got=%0d exp=1", done_n_a - dn0); end
    assert_cnt++; if (done_cyc_a - acc != 137) begin fail_cnt++; $display("FAIL a5_done_time got=%0d exp=137", done_cyc_a - acc); end
    exp_q.delete();
  endtask

  task automatic test_clkdiv1;
    int acc, rc;
    bit to;
    logic [15:0] got;
    send(1'b1, 8'hFF, acc, to);
    assert_cnt++; if (to) begin fail_cnt++; $display("FAIL ff_accept got=timeout exp=accept"); end
    wait_ready(1'b1, rc, to);
    assert_cnt++; if (to || rc - acc != 36) begin fail_cnt++; $display("FAIL ff_ready_latency got=%0d exp=36", rc - acc); end
    wait_frames(1'b1, 1, to);
    assert_cnt++; if (to) begin fail_cnt++; $display("FAIL ff_frame got=timeout exp=frame"); end
    if (!to) begin
      got = got_b.pop_front();
      assert_cnt++; if (got !== 16'h3FF0) begin fail_cnt++; $display("FAIL ff_bits got=%h exp=3ff0", got); end
      assert_cnt++; if (len_b[0] != 34) begin fail_cnt++; $display("FAIL ff_cs_low got=%0d exp=34", len_b[0]); end
      assert_cnt++; if (bits_b[0] != 16) begin fail_cnt++; $display("FAIL ff_rising_edges got=%0d exp=16", bits_b[0]); end
      void'(bits_b.pop_front()); void'(len_b.pop_front());
    end
    assert_cnt++; if (gap_bad_b != 0) begin fail_cnt++; $display("FAIL ff_sclk_period got=%0d bad gaps exp=0", gap_bad_b); end
    assert_cnt++; if (viol_b != 0) begin fail_cnt++; $display("FAIL ff_mosi_stable got=%0d exp=0", viol_b); end
  endtask

  task automatic test_back_to_back;
    int acc1, acc2, low_cnt, busy_lo, dn0, i;
    bit to;
    logic [15:0] got, exp;
    dn0 = done_n_a;
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0800);
    din_a = 8'h01; valid_a = 1'b1;
    acc1 = cyc;
    @(negedge clk);
    din_a = 8'h80;
    low_cnt = 0; busy_lo = 0; i = 0;
    while (i < 500 && ready_a !== 1'b1) begin
      low_cnt++;
      if (busy_a !== 1'b1) busy_lo++;
      @(negedge clk); i++;
    end
    acc2 = cyc;
    @(negedge clk);
    valid_a = 1'b0;
    assert_cnt++; if (low_cnt != 140) begin fail_cnt++; $display("FAIL b2b_ready_low got=%0d exp=140", low_cnt); end
    assert_cnt++; if (acc2 - acc1 != 141) begin fail_cnt++; $display("FAIL b2b_spacing got=%0d exp=141", acc2 - acc1); end
    assert_cnt++; if (busy_lo != 0) begin fail_cnt++; $display("FAIL b2b_busy_gap got=%0d exp=0", busy_lo); end
    wait_frames(1'b0, 2, to);
    assert_cnt++; if (to) begin fail_cnt++; $display("FAIL b2b_frames got=timeout exp=2 frames"); end
    while (got_a.size() > 0 && exp_q.size() > 0) begin
      got = got_a.pop_front(); exp = exp_q.pop_front();
      assert_cnt++; if (got !== exp) begin fail_cnt++; $display("FAIL b2b_bits got=%h exp=%h", got, exp); end
    end
    repeat (3) @(negedge clk);
    assert_cnt++; if (done_n_a - dn0 != 2) begin fail_cnt++; $display("FAIL b2b_done_count got=%0d exp=2", done_n_a - dn0); end
    exp_q.delete(); bits_a.delete(); len_a.delete();
  endtask

  task automatic test_reset_abort;
    int acc, dn0, i, cs_low;
    bit to;
    logic [15:0] got;
    send(1'b0, 8'h3C, acc, to);
    i = 0;
    while (i < 500 && nbits_a < 7) begin @(negedge clk); i++; end
    assert_cnt++; if (i >= 500) begin fail_cnt++; $display("FAIL abort_reach_edge7 got=timeout exp=7 edges"); end
    dn0 = done_n_a;
    rst_n = 1'b0;
    #1;
    assert_cnt++; if (cs_a !== 1'b1) begin fail_cnt++; $display("FAIL abort_cs_n got=%b exp=1", cs_a); end
    assert_cnt++; if (sclk_a !== 1'b0) begin fail_cnt++; $display("FAIL abort_sclk got=%b exp=0", sclk_a); end
    assert_cnt++; if (busy_a !== 1'b0) begin fail_cnt++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    assert_cnt++; if (ready_a !== 1'b1) begin fail_cnt++; $display("FAIL abort_ready got=%b exp=1", ready_a); end
    cs_low = 0;
    repeat (200) begin @(negedge clk); if (cs_a !== 1'b1) cs_low++; end
    assert_cnt++; if (cs_low != 0) begin fail_cnt++; $display("FAIL abort_no_retx got=%0d cs low cycles exp=0", cs_low); end
    assert_cnt++; if (done_n_a != dn0) begin fail_cnt++; $display("FAIL abort_no_done got=%0d exp=%0d", done_n_a, dn0); end
    assert_cnt++; if (got_a.size() != 0) begin fail_cnt++; $display("FAIL abort_no_frame got=%0d exp=0", got_a.size()); end
    got_a.delete(); bits_a.delete(); len_a.delete();
    send(1'b0, 8'h55, acc, to);
    wait_frames(1'b0, 1, to);
    assert_cnt++; if (to) begin fail_cnt++; $display("FAIL post_abort_frame got=timeout exp=frame"); end
    if (!to) begin
      got = got_a.pop_front();
      assert_cnt++; if (got !== 16'h0550) begin fail_cnt++; $display("FAIL post_abort_bits got=%h exp=0550", got); end
      assert_cnt++; if (bits_a[0] != 16) begin fail_cnt++; $display("FAIL post_abort_edges got=%0d exp=16", bits_a[0]); end
    end
    bits_a.delete(); len_a.delete();
  endtask

  task automatic test_din_change;
    int acc, v0;
    bit to;
    logic [15:0] got;
    v0 = viol_a;
    send(1'b0, 8'h12, acc, to);
    repeat (40) @(negedge clk);
    din_a = 8'hEE;
    wait_frames(1'b0, 1, to);
    assert_cnt++; if (to) begin fail_cnt++; $display("FAIL din_change_frame got=timeout exp=frame"); end
    if (!to) begin
      got = got_a.pop_front();
      assert_cnt++; if (got !== 16'h0120) begin fail_cnt++; $display("FAIL din_change_bits got=%h exp=0120", got); end
    end
    assert_cnt++; if (viol_a != 0) begin fail_cnt++; $display("FAIL mosi_stable_sclk_high got=%0d exp=0 (delta %0d)", viol_a, viol_a - v0); end
    repeat (10) @(negedge clk);
    assert_cnt++; if (got_a.size() != 0) begin fail_cnt++; $display("FAIL din_change_extra_frame got=%0d exp=0", got_a.size()); end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_clkdiv1();
    test_back_to_back();
    test_reset_abort();
    test_din_change();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
